// File: rtl/io_wait_controller.sv
// I/O wait controller: stalls the PC on IN until the operator confirms, latches OUT values.
// Optional build macro IO_TIMEOUT_EN adds a wait limit and the TimedOut output.
module io_wait_controller #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SWITCH_WIDTH    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 100000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Halt,
    input  logic                    OpIO,
    input  logic                    RegWrite,
    input  logic [SWITCH_WIDTH-1:0] Switches,
    input  logic                    Confirm,
    input  logic [DATA_WIDTH-1:0]   OutValue,
    output logic                    PcEnable,
    output logic [DATA_WIDTH-1:0]   InData,
    output logic                    InValid,
    output logic [DATA_WIDTH-1:0]   Display,
    output logic                    OutStrobe,
    output logic                    Waiting
`ifdef IO_TIMEOUT_EN
    ,
    output logic                    TimedOut
`endif
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun         = 2'd0,
        StWaitPress   = 2'd1,
        StWaitRelease = 2'd2,
        StResume      = 2'd3
    } state_e;

    state_e                  r_state;
    logic                    r_sync1;
    logic                    r_conf_s;
    logic                    r_conf_d;
    logic                    r_conf_d_prev;
    logic [DbW-1:0]          r_db_cnt;
    logic [DATA_WIDTH-1:0]   r_in_data;
    logic [DATA_WIDTH-1:0]   r_display;
    logic                    r_in_valid;
    logic                    r_out_strobe;
    logic                    r_waiting;

    logic                    w_in_req;
    logic                    w_out_req;
    logic                    w_press;
    logic                    w_release;
    logic                    w_timeout;
    logic [DATA_WIDTH-1:0]   w_switch_ext;

    assign w_in_req     = Halt & OpIO & RegWrite;
    assign w_out_req    = OpIO & ~RegWrite & ~Halt;
    assign w_press      = r_conf_d & ~r_conf_d_prev;
    assign w_release    = ~r_conf_d & r_conf_d_prev;
    assign w_switch_ext = DATA_WIDTH'(Switches);

    // Two-flop synchroniser followed by a stable-level debouncer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1       <= 1'b0;
            r_conf_s      <= 1'b0;
            r_conf_d      <= 1'b0;
            r_conf_d_prev <= 1'b0;
            r_db_cnt      <= '0;
        end else begin
            r_sync1       <= Confirm;
            r_conf_s      <= r_sync1;
            r_conf_d_prev <= r_conf_d;
            if (r_conf_s != r_conf_d) begin
                if (r_db_cnt == DbMax) begin
                    r_conf_d <= r_conf_s;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] r_wait_cnt;
    logic           r_timed_out;

    assign w_timeout = (r_wait_cnt == ToMax);

    // Counter is held at zero in RUN so every wait starts from a clean count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if ((r_state == StWaitPress) || (r_state == StWaitRelease)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            r_timed_out <= w_timeout &
                           (((r_state == StWaitPress) & ~w_press) |
                            ((r_state == StWaitRelease) & ~w_release));
        end
    end

    assign TimedOut = r_timed_out;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= StRun;
            r_in_data    <= '0;
            r_display    <= '0;
            r_in_valid   <= 1'b0;
            r_out_strobe <= 1'b0;
            r_waiting    <= 1'b0;
        end else begin
            r_in_valid   <= 1'b0;
            r_out_strobe <= 1'b0;
            unique case (r_state)
                StRun: begin
                    if (w_in_req) begin
                        r_state   <= StWaitPress;
                        r_waiting <= 1'b1;
                    end else if (w_out_req) begin
                        r_display    <= OutValue;
                        r_out_strobe <= 1'b1;
                    end
                end
                StWaitPress: begin
                    // Only a fresh rising edge counts; a button held on entry is ignored.
                    if (w_press) begin
                        r_in_data <= w_switch_ext;
                        r_state   <= StWaitRelease;
                    end else if (w_timeout) begin
                        r_in_data  <= '0;
                        r_state    <= StResume;
                        r_in_valid <= 1'b1;
                        r_waiting  <= 1'b0;
                    end
                end
                StWaitRelease: begin
                    if (w_release || w_timeout) begin
                        r_state    <= StResume;
                        r_in_valid <= 1'b1;
                        r_waiting  <= 1'b0;
                    end
                end
                StResume: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    // The IN stall must act in the decode cycle itself, hence combinational.
    assign PcEnable = ~(((r_state == StRun) & w_in_req) |
                        (r_state == StWaitPress) | (r_state == StWaitRelease));

    assign InData    = r_in_data;
    assign InValid   = r_in_valid;
    assign Display   = r_display;
    assign OutStrobe = r_out_strobe;
    assign Waiting   = r_waiting;

endmodule

// File: tb/tb_io_wait_controller.sv
// Directed bench for io_wait_controller (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
// Define IO_TIMEOUT_EN to also exercise the timeout path.
module tb_io_wait_controller;

    logic        clock;
    logic        reset;
    logic        Halt;
    logic        OpIO;
    logic        RegWrite;
    logic [15:0] Switches;
    logic        Confirm;
    logic [31:0] OutValue;
    logic        PcEnable;
    logic [31:0] InData;
    logic        InValid;
    logic [31:0] Display;
    logic        OutStrobe;
    logic        Waiting;
`ifdef IO_TIMEOUT_EN
    logic        TimedOut;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;
    bit in_flight = 0;
    logic [31:0] exp_in = '0;

    io_wait_controller #(
        .DATA_WIDTH      (32),
        .SWITCH_WIDTH    (16),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .Halt      (Halt),
        .OpIO      (OpIO),
        .RegWrite  (RegWrite),
        .Switches  (Switches),
        .Confirm   (Confirm),
        .OutValue  (OutValue),
        .PcEnable  (PcEnable),
        .InData    (InData),
        .InValid   (InValid),
        .Display   (Display),
        .OutStrobe (OutStrobe),
        .Waiting   (Waiting)
`ifdef IO_TIMEOUT_EN
        ,
        .TimedOut  (TimedOut)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_in(input logic [15:0] sw);
        Switches = sw;
        exp_in   = {16'h0000, sw};
        Halt     = 1'b1;
        OpIO     = 1'b1;
        RegWrite = 1'b1;
        n_pulses = 0;
        in_flight = 1'b1;
        #1;
        chk("stall_in_decode", {31'b0, PcEnable}, 32'd0);
    endtask

    // Hold Confirm at v for n cycles; retire the IN as soon as InValid is seen.
    task automatic drive_conf(input logic v, input int n);
        Confirm = v;
        for (int i = 0; i < n; i++) begin
            tick();
            if (InValid) begin
                n_pulses++;
                chk("resume_pc_enable", {31'b0, PcEnable}, 32'd1);
                chk("resume_in_data", InData, exp_in);
`ifdef IO_TIMEOUT_EN
                chk("no_timeout_on_press", {31'b0, TimedOut}, 32'd0);
`endif
                Halt      = 1'b0;
                OpIO      = 1'b0;
                RegWrite  = 1'b0;
                in_flight = 1'b0;
            end else if (in_flight) begin
                chk("stall_while_waiting", {31'b0, PcEnable}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        Halt     = 1'b0;
        OpIO     = 1'b0;
        RegWrite = 1'b0;
        Switches = '0;
        Confirm  = 1'b0;
        OutValue = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_pc_enable", {31'b0, PcEnable}, 32'd1);
        chk("rst_in_data", InData, 32'd0);
        chk("rst_in_valid", {31'b0, InValid}, 32'd0);
        chk("rst_display", Display, 32'd0);
        chk("rst_out_strobe", {31'b0, OutStrobe}, 32'd0);
        chk("rst_waiting", {31'b0, Waiting}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic IN with a clean press/release
        issue_in(16'h00A5);
        tick();
        chk("wait_press_waiting", {31'b0, Waiting}, 32'd1);
        chk("wait_press_stall", {31'b0, PcEnable}, 32'd0);
        drive_conf(1'b1, 10);
        drive_conf(1'b0, 10);
        chk("in1_pulses", n_pulses, 32'd1);
        chk("in1_data", InData, 32'h0000_00A5);
        chk("in1_waiting_clear", {31'b0, Waiting}, 32'd0);

        // Short bounces must not capture
        issue_in(16'h1234);
        drive_conf(1'b1, 2);
        drive_conf(1'b0, 2);
        drive_conf(1'b1, 2);
        drive_conf(1'b0, 4);
        chk("bounce_pulses", n_pulses, 32'd0);
        chk("bounce_no_capture", InData, 32'h0000_00A5);
        chk("bounce_waiting", {31'b0, Waiting}, 32'd1);
        drive_conf(1'b1, 10);
        drive_conf(1'b0, 10);
        chk("bounce_then_clean_pulses", n_pulses, 32'd1);
        chk("bounce_then_clean_data", InData, 32'h0000_1234);

        // Button held before the IN decode
        drive_conf(1'b1, 10);
        issue_in(16'h0F0F);
        drive_conf(1'b1, 10);
        chk("held_no_pulse", n_pulses, 32'd0);
        chk("held_no_capture", InData, 32'h0000_1234);
        drive_conf(1'b0, 10);
        chk("held_release_no_pulse", n_pulses, 32'd0);
        chk("held_release_waiting", {31'b0, Waiting}, 32'd1);
        drive_conf(1'b1, 10);
        drive_conf(1'b0, 10);
        chk("held_fresh_pulses", n_pulses, 32'd1);
        chk("held_fresh_data", InData, 32'h0000_0F0F);

        // OUT
        OutValue = 32'hDEAD_BEEF;
        OpIO     = 1'b1;
        RegWrite = 1'b0;
        Halt     = 1'b0;
        #1;
        chk("out_pc_enable", {31'b0, PcEnable}, 32'd1);
        tick();
        OpIO     = 1'b0;
        OutValue = '0;
        #1;
        chk("out_display", Display, 32'hDEAD_BEEF);
        chk("out_strobe_high", {31'b0, OutStrobe}, 32'd1);
        chk("out_pc_enable_after", {31'b0, PcEnable}, 32'd1);
        tick();
        chk("out_strobe_low", {31'b0, OutStrobe}, 32'd0);
        chk("out_display_hold", Display, 32'hDEAD_BEEF);

        // Reset during WAIT_RELEASE
        issue_in(16'h00C3);
        drive_conf(1'b1, 10);
        chk("rel_captured", InData, 32'h0000_00C3);
        chk("rel_waiting", {31'b0, Waiting}, 32'd1);
        reset    = 1'b0;
        Halt     = 1'b0;
        OpIO     = 1'b0;
        RegWrite = 1'b0;
        Confirm  = 1'b0;
        in_flight = 1'b0;
        tick();
        chk("midrst_in_data", InData, 32'd0);
        chk("midrst_waiting", {31'b0, Waiting}, 32'd0);
        chk("midrst_pc_enable", {31'b0, PcEnable}, 32'd1);
        chk("midrst_in_valid", {31'b0, InValid}, 32'd0);
        reset = 1'b1;
        tick();

`ifdef IO_TIMEOUT_EN
        // No press: forced resume after 64 wait cycles
        begin
            int cyc;
            cyc = 0;
            issue_in(16'h0055);
            while (!InValid && cyc < 100) begin
                tick();
                cyc++;
            end
            chk("to_cycles", cyc, 32'd65);
            chk("to_in_valid", {31'b0, InValid}, 32'd1);
            chk("to_timed_out", {31'b0, TimedOut}, 32'd1);
            chk("to_in_data", InData, 32'd0);
            chk("to_pc_enable", {31'b0, PcEnable}, 32'd1);
            Halt      = 1'b0;
            OpIO      = 1'b0;
            RegWrite  = 1'b0;
            in_flight = 1'b0;
            tick();
            chk("to_pulse_end", {31'b0, TimedOut}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
